// File: rtl/aes_dec_key_schedule.sv
// Iterative AES-128 key schedule for the decrypt datapath: expands the cipher key
// forward to round key 10, then streams round keys 10..0 back out one per handshake.
module aes_dec_key_schedule #(
  parameter bit EQUIV_INV = 1'b1
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Key_valid,
  output logic         Key_ready,
  input  logic [127:0] Key,
  output logic         Round_key_valid,
  input  logic         Round_key_ready,
  output logic [127:0] Round_key,
  output logic [3:0]   Round_num,
  output logic         Last
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, EMIT = 2'd2} state_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] inv_xtime(input logic [7:0] b);
    return b[0] ? (((b ^ 8'h1b) >> 1) | 8'h80) : (b >> 1);
  endfunction

  // Byte 0x00 sits in the top byte of the table.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (c[0] ? b : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [31:0] imc_word(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
            gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
            gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
  endfunction

  function automatic logic [127:0] fwd_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h000000};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo one forward round: recover the older w3..w1 first, then w0 from the older w3.
  function automatic logic [127:0] bwd_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] b0, b1, b2, b3;
    b3 = k[31:0] ^ k[63:32];
    b2 = k[63:32] ^ k[95:64];
    b1 = k[95:64] ^ k[127:96];
    b0 = k[127:96] ^ sub_rot(b3) ^ {rc, 24'h000000};
    return {b0, b1, b2, b3};
  endfunction

  state_t         state_q, state_d;
  logic [127:0]   key_q, key_d;
  logic [7:0]     rcon_q, rcon_d;
  logic [3:0]     round_q, round_d;
  logic           key_ready_q, key_ready_d;
  logic           valid_q, valid_d;
  logic           last_q, last_d;

  // Next-state logic for the IDLE / EXPAND / EMIT sequence.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    rcon_d      = rcon_q;
    round_d     = round_q;
    key_ready_d = key_ready_q;
    valid_d     = valid_q;
    last_d      = last_q;
    case (state_q)
      IDLE: begin
        if (Key_valid && key_ready_q) begin
          key_d       = Key;
          round_d     = 4'd0;
          rcon_d      = 8'h01;
          key_ready_d = 1'b0;
          state_d     = EXPAND;
        end else begin
          key_ready_d = 1'b1;
        end
      end
      EXPAND: begin
        key_d   = fwd_step(key_q, rcon_q);
        round_d = round_q + 4'd1;
        // rcon stays at 0x36 after the last round: it is the first one the reverse walk needs.
        if (round_q == 4'd9) begin
          state_d = EMIT;
          valid_d = 1'b1;
          last_d  = 1'b0;
        end else begin
          rcon_d = xtime(rcon_q);
        end
      end
      EMIT: begin
        if (valid_q && Round_key_ready) begin
          if (round_q == 4'd0) begin
            state_d     = IDLE;
            valid_d     = 1'b0;
            last_d      = 1'b0;
            key_ready_d = 1'b1;
          end else begin
            key_d   = bwd_step(key_q, rcon_q);
            rcon_d  = inv_xtime(rcon_q);
            round_d = round_q - 4'd1;
            last_d  = (round_q == 4'd1);
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d     = IDLE;
        valid_d     = 1'b0;
        last_d      = 1'b0;
        key_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      key_q       <= 128'h0;
      rcon_q      <= 8'h01;
      round_q     <= 4'd0;
      key_ready_q <= 1'b1;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      rcon_q      <= rcon_d;
      round_q     <= round_d;
      key_ready_q <= key_ready_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
    end
  end

  // Equivalent Inverse Cipher keys for the middle rounds; 10 and 0 always leave raw.
  always_comb begin
    if (EQUIV_INV && (state_q == EMIT) && (round_q >= 4'd1) && (round_q <= 4'd9)) begin
      Round_key = {imc_word(key_q[127:96]), imc_word(key_q[95:64]),
                   imc_word(key_q[63:32]), imc_word(key_q[31:0])};
    end else begin
      Round_key = key_q;
    end
  end

  assign Key_ready       = key_ready_q;
  assign Round_key_valid = valid_q;
  assign Round_num       = round_q;
  assign Last            = last_q;

endmodule

// File: tb/tb_aes_dec_key_schedule.sv
// Directed bench: a raw-key instance and an equivalent-inverse instance share one stimulus
// stream and are checked against FIPS-197 round keys and an independent InvMixColumns model.
module tb_aes_dec_key_schedule;

  logic         Clk = 1'b0;
  logic         Rst, Key_valid, Round_key_ready;
  logic [127:0] Key;
  logic         kr_a, v_a, last_a, kr_b, v_b, last_b;
  logic [127:0] rk_a, rk_b;
  logic [3:0]   num_a, num_b;

  int checks = 0;
  int failures = 0;

  localparam logic [127:0] KEY1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY2    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY2_10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic [127:0] exp_rk [0:10];

  always #5 Clk = ~Clk;

  aes_dec_key_schedule #(.EQUIV_INV(1'b0)) u_raw (
    .Clk(Clk), .Rst(Rst), .Key_valid(Key_valid), .Key_ready(kr_a), .Key(Key),
    .Round_key_valid(v_a), .Round_key_ready(Round_key_ready), .Round_key(rk_a),
    .Round_num(num_a), .Last(last_a));

  aes_dec_key_schedule #(.EQUIV_INV(1'b1)) u_eq (
    .Clk(Clk), .Rst(Rst), .Key_valid(Key_valid), .Key_ready(kr_b), .Key(Key),
    .Round_key_valid(v_b), .Round_key_ready(Round_key_ready), .Round_key(rk_b),
    .Round_num(num_b), .Last(last_b));

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add GF(2^8) multiply.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] m);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] imc_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] r [4];
    logic [7:0] row [4];
    row = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int j = 0; j < 4; j++) a[j] = c[31 - 8*j -: 8];
    for (int i = 0; i < 4; i++) begin
      r[i] = 8'h00;
      for (int j = 0; j < 4; j++) r[i] = r[i] ^ gm(a[j], row[(j - i + 4) % 4]);
    end
    return {r[0], r[1], r[2], r[3]};
  endfunction

  function automatic logic [127:0] imc128(input logic [127:0] k);
    return {imc_col(k[127:96]), imc_col(k[95:64]), imc_col(k[63:32]), imc_col(k[31:0])};
  endfunction

  function automatic logic [127:0] eq_exp(input int n);
    return (n >= 1 && n <= 9) ? imc128(exp_rk[n]) : exp_rk[n];
  endfunction

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_kready"}, 128'(kr_a), 128'd1);
    chk({tag, "_valid"}, 128'(v_a), 128'd0);
    chk({tag, "_last"}, 128'(last_a), 128'd0);
    chk({tag, "_num"}, 128'(num_a), 128'd0);
    chk({tag, "_rk"}, rk_a, 128'd0);
    chk({tag, "_eq_kready"}, 128'(kr_b), 128'd1);
    chk({tag, "_eq_valid"}, 128'(v_b), 128'd0);
    chk({tag, "_eq_rk"}, rk_b, 128'd0);
  endtask

  task automatic load(input logic [127:0] k, input bit keep_valid);
    Key = k;
    Key_valid = 1'b1;
    tick;
    Key_valid = keep_valid;
    chk("load_kready_low", 128'(kr_a), 128'd0);
  endtask

  // Key accepted on the previous edge: valid must appear exactly ten edges later.
  task automatic wait_first(input string tag);
    repeat (9) tick;
    chk({tag, "_valid_early"}, 128'(v_a), 128'd0);
    tick;
    chk({tag, "_valid_on_time"}, 128'(v_a), 128'd1);
    chk({tag, "_num10"}, 128'(num_a), 128'd10);
  endtask

  task automatic stream(input string tag, input int start_n, input bit rand_ready, input bit scramble);
    int n;
    int cyc;
    n = start_n;
    cyc = 0;
    while (n >= 0 && cyc < 400) begin
      if (scramble) Key = {$urandom(), $urandom(), $urandom(), $urandom()};
      Round_key_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v_a && Round_key_ready) begin
        chk({tag, "_num"}, 128'(num_a), 128'(n));
        chk({tag, "_eq_num"}, 128'(num_b), 128'(n));
        chk({tag, "_rk"}, rk_a, exp_rk[n]);
        chk({tag, "_eq_rk"}, rk_b, eq_exp(n));
        chk({tag, "_last"}, 128'(last_a), 128'(n == 0));
        n--;
      end
      tick;
      cyc++;
    end
    chk({tag, "_handshakes"}, 128'(start_n - n), 128'(start_n + 1));
    Key_valid = 1'b0;
    Round_key_ready = 1'b1;
    chk({tag, "_end_valid"}, 128'(v_a), 128'd0);
    chk({tag, "_end_kready"}, 128'(kr_a), 128'd1);
  endtask

  initial begin
    exp_rk[0]  = KEY1;
    exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    Rst = 1'b1;
    Key_valid = 1'b0;
    Key = 128'h0;
    Round_key_ready = 1'b1;
    tick;
    tick;
    Rst = 1'b0;
    check_reset("rst0");

    // InvMixColumns model against known MixColumns column pairs.
    chk("imc_model_a", 128'(imc_col(32'h8e4da1bc)), 128'h00000000_00000000_00000000_db135345);
    chk("imc_model_b", 128'(imc_col(32'h9fdc589d)), 128'h00000000_00000000_00000000_f20a225c);

    load(KEY1, 1'b0);
    wait_first("k1");
    stream("k1", 10, 1'b0, 1'b0);

    load(KEY2, 1'b0);
    wait_first("k2");
    chk("k2_rk10", rk_a, KEY2_10);
    chk("k2_eq_rk10", rk_b, KEY2_10);
    repeat (10) tick;
    chk("k2_num0", 128'(num_a), 128'd0);
    chk("k2_last", 128'(last_a), 128'd1);
    chk("k2_rk0", rk_a, KEY2);
    chk("k2_eq_rk0", rk_b, KEY2);
    tick;
    chk("k2_end_valid", 128'(v_a), 128'd0);
    chk("k2_end_kready", 128'(kr_a), 128'd1);

    load(KEY1, 1'b0);
    wait_first("bp");
    repeat (3) tick;
    chk("bp_num7", 128'(num_a), 128'd7);
    Round_key_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_hold_num", 128'(num_a), 128'd7);
      chk("bp_hold_rk", rk_a, exp_rk[7]);
      chk("bp_hold_eq_rk", rk_b, imc128(exp_rk[7]));
      chk("bp_hold_valid", 128'(v_a), 128'd1);
      chk("bp_hold_last", 128'(last_a), 128'd0);
    end
    stream("bp", 7, 1'b0, 1'b0);

    load(KEY1, 1'b0);
    stream("rnd", 10, 1'b1, 1'b0);

    load(KEY1, 1'b0);
    repeat (3) tick;
    Rst = 1'b1;
    tick;
    Rst = 1'b0;
    check_reset("rst_exp");
    load(KEY1, 1'b0);
    wait_first("rst_exp_rerun");
    chk("rst_exp_rerun_rk10", rk_a, exp_rk[10]);
    repeat (5) tick;
    chk("rst_emit_num5", 128'(num_a), 128'd5);
    Rst = 1'b1;
    tick;
    Rst = 1'b0;
    check_reset("rst_emit");
    tick;
    chk("rst_emit_quiet", 128'(v_a), 128'd0);

    load(KEY1, 1'b1);
    stream("kv_ignore", 10, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
